// File: rtl/des_keysched_seq.sv
// rtl/des_keysched_seq.sv - sequential DES/3DES round-key generator with valid/ready output
// Optional odd-parity key check on load: define KEYSCHED_PARITY_CHK_EN.

module perm2 (
  input  logic [55:0] cd_i,
  output logic [47:0] rk_o
);

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // DES bit n (1 = MSB) of the 56-bit C||D word is cd_i[56-n].
  always_comb begin
    rk_o = '0;
    for (int i = 0; i < 48; i++) begin
      rk_o[47 - i] = cd_i[56 - PC2[i]];
    end
  end

endmodule

module des_keysched_seq #(
  parameter int NKEYS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [64*NKEYS-1:0]  key_i,
  input  logic [NKEYS-1:0]     dec_i,
  input  logic                 load_i,
  output logic                 busy_o,
  output logic [47:0]          rk_o,
  output logic                 rk_valid_o,
  input  logic                 rk_ready_i,
  output logic [3:0]           rk_round_o,
  output logic [1:0]           rk_kidx_o,
  output logic                 rk_last_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam logic [1:0] KIDX_LAST = 2'(NKEYS - 1);

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55 - i] = k[64 - PC1[i]];
    end
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic right, input logic one);
    case ({right, one})
      2'b01:   rot28 = {x[26:0], x[27]};
      2'b00:   rot28 = {x[25:0], x[27:26]};
      2'b11:   rot28 = {x[0], x[27:1]};
      default: rot28 = {x[1:0], x[27:2]};
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [56*NKEYS-1:0] kpc_q, kpc_d;
  logic [NKEYS-1:0]    dec_q, dec_d;
  logic [27:0]         c_q, c_d;
  logic [27:0]         d_q, d_d;
  logic [3:0]          round_q, round_d;
  logic [1:0]          kidx_q, kidx_d;
  logic                last_q, last_d;

  logic [55:0]         cd0;
  logic                dec_sel;
  logic                one_step;
  logic                load_ok;

`ifdef KEYSCHED_PARITY_CHK_EN
  logic err_q, err_d;
  logic par_ok;

  always_comb begin
    par_ok = 1'b1;
    for (int b = 0; b < 8*NKEYS; b++) begin
      par_ok = par_ok & (^key_i[8*b +: 8]);
    end
  end

  assign load_ok = par_ok;
  assign err_o   = err_q;
`else
  logic unused_key_par;

  assign unused_key_par = ^key_i;
  assign load_ok        = 1'b1;
  assign err_o          = 1'b0;
`endif

  // Keys are stored already PC-1 permuted, so PREP only selects and pre-rotates.
  always_comb begin
    cd0     = kpc_q[55:0];
    dec_sel = dec_q[0];
    for (int k = 1; k < NKEYS; k++) begin
      if (kidx_q == 2'(k)) begin
        cd0     = kpc_q[56*k +: 56];
        dec_sel = dec_q[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    kpc_d    = kpc_q;
    dec_d    = dec_q;
    c_d      = c_q;
    d_d      = d_q;
    round_d  = round_q;
    kidx_d   = kidx_q;
    // Single-bit steps land on the rounds entered as 1, 8 and 15 in both directions.
    one_step = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);
`ifdef KEYSCHED_PARITY_CHK_EN
    err_d    = (state_q == S_IDLE) && load_i && !par_ok;
`endif

    case (state_q)
      S_IDLE: begin
        if (load_i && load_ok) begin
          for (int k = 0; k < NKEYS; k++) begin
            kpc_d[56*k +: 56] = pc1(key_i[64*k +: 64]);
          end
          dec_d   = dec_i;
          kidx_d  = '0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        round_d = '0;
        c_d     = dec_sel ? cd0[55:28] : rot28(cd0[55:28], 1'b0, 1'b1);
        d_d     = dec_sel ? cd0[27:0]  : rot28(cd0[27:0],  1'b0, 1'b1);
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (rk_ready_i) begin
          if (round_q != 4'd15) begin
            round_d = round_q + 4'd1;
            c_d     = rot28(c_q, dec_sel, one_step);
            d_d     = rot28(d_q, dec_sel, one_step);
          end else if (kidx_q != KIDX_LAST) begin
            kidx_d  = kidx_q + 2'd1;
            state_d = S_PREP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    last_d = (state_d == S_EMIT) && (round_d == 4'd15) && (kidx_d == KIDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kpc_q   <= '0;
      dec_q   <= '0;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      kidx_q  <= '0;
      last_q  <= 1'b0;
`ifdef KEYSCHED_PARITY_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      kpc_q   <= kpc_d;
      dec_q   <= dec_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      kidx_q  <= kidx_d;
      last_q  <= last_d;
`ifdef KEYSCHED_PARITY_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign rk_valid_o = (state_q == S_EMIT);
  assign rk_round_o = round_q;
  assign rk_kidx_o  = kidx_q;
  assign rk_last_o  = last_q;

  perm2 u_perm2 (
    .cd_i ({c_q, d_q}),
    .rk_o (rk_o)
  );

endmodule

// File: tb/tb_des_keysched_seq.sv
// tb/tb_des_keysched_seq.sv - scoreboard bench for des_keysched_seq (DES and 3DES instances)
module tb_des_keysched_seq;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_Z = 64'h0101010101010101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic ready = 1'b1;

  logic [63:0]  key1  = '0;
  logic [0:0]   dec1  = '0;
  logic         load1 = 1'b0;
  logic         busy1, valid1, last1, err1;
  logic [47:0]  rk1;
  logic [3:0]   round1;
  logic [1:0]   kidx1;

  logic [191:0] key3  = '0;
  logic [2:0]   dec3  = '0;
  logic         load3 = 1'b0;
  logic         busy3, valid3, last3, err3;
  logic [47:0]  rk3;
  logic [3:0]   round3;
  logic [1:0]   kidx3;

  int n_checks = 0;
  int n_fail   = 0;
  int hs1 = 0, hs3 = 0, busy_cnt1 = 0, busy_cnt3 = 0;
  logic [54:0] exp_q1[$];
  logic [54:0] exp_q3[$];

  // Round keys K1..K16 of KEY_A, hand-derived.
  logic [47:0] ktab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_keysched_seq #(.NKEYS(1)) u_des (
    .clk(clk), .rst_n(rst_n), .key_i(key1), .dec_i(dec1), .load_i(load1),
    .busy_o(busy1), .rk_o(rk1), .rk_valid_o(valid1), .rk_ready_i(ready),
    .rk_round_o(round1), .rk_kidx_o(kidx1), .rk_last_o(last1), .err_o(err1)
  );

  des_keysched_seq #(.NKEYS(3)) u_tdes (
    .clk(clk), .rst_n(rst_n), .key_i(key3), .dec_i(dec3), .load_i(load3),
    .busy_o(busy3), .rk_o(rk3), .rk_valid_o(valid3), .rk_ready_i(ready),
    .rk_round_o(round3), .rk_kidx_o(kidx3), .rk_last_o(last3), .err_o(err3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // sel: 0 = KEY_A schedule, 1 = complemented key, 2 = all-zero schedule.
  task automatic push_key(input bit tdes, input int kidx, input int sel, input bit d, input bit last_key);
    logic [47:0] rk;
    logic        l;
    for (int r = 0; r < 16; r++) begin
      rk = ktab[d ? 15 - r : r];
      if (sel == 1) rk = ~rk;
      else if (sel == 2) rk = '0;
      l = last_key && (r == 15);
      if (tdes) exp_q3.push_back({l, 2'(kidx), 4'(r), rk});
      else      exp_q1.push_back({l, 2'(kidx), 4'(r), rk});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy1) busy_cnt1++;
      if (valid1 && exp_q1.size() == 0) check("spurious_key1", valid1, 1'b0);
      else if (valid1 && ready) check("rk1", {last1, kidx1, round1, rk1}, exp_q1.pop_front());
      else if (valid1) check("hold1", {last1, kidx1, round1, rk1}, exp_q1[0]);
      if (valid1 && ready) hs1++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy3) busy_cnt3++;
      if (valid3 && exp_q3.size() == 0) check("spurious_key3", valid3, 1'b0);
      else if (valid3 && ready) check("rk3", {last3, kidx3, round3, rk3}, exp_q3.pop_front());
      else if (valid3) check("hold3", {last3, kidx3, round3, rk3}, exp_q3[0]);
      if (valid3 && ready) hs3++;
    end
  end

  task automatic load_des(input logic [63:0] k, input logic d);
    @(posedge clk); #1;
    key1 = k; dec1 = d; load1 = 1'b1; busy_cnt1 = 0; hs1 = 0;
    @(posedge clk); #1;
    load1 = 1'b0; key1 = ~k; dec1 = ~d;
    check("prep_valid1", valid1, 1'b0);
    check("prep_busy1", busy1, 1'b1);
    @(posedge clk); #1;
    check("emit_valid1", valid1, 1'b1);
  endtask

  task automatic load_tdes(input logic [191:0] k, input logic [2:0] d);
    @(posedge clk); #1;
    key3 = k; dec3 = d; load3 = 1'b1; busy_cnt3 = 0; hs3 = 0;
    @(posedge clk); #1;
    load3 = 1'b0; key3 = ~k; dec3 = ~d;
    check("prep_valid3", valid3, 1'b0);
    @(posedge clk); #1;
    check("emit_valid3", valid3, 1'b1);
  endtask

  task automatic drain(input bit rnd, input bit pulse1, input bit pulse3, input int budget);
    int i;
    i = 0;
    while ((exp_q1.size() != 0 || exp_q3.size() != 0 || busy1 || busy3) && i < budget) begin
      @(posedge clk); #1;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      load1 = pulse1 && (i == 5);
      load3 = pulse3 && (i == 9);
      i++;
    end
    check("drain_in_budget", 64'(i < budget), 64'd1);
    ready = 1'b1; load1 = 1'b0; load3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", busy1, 1'b0);
    check("rst_valid", valid1, 1'b0);
    check("rst_rk", rk1, 48'h0);
    check("rst_round", round1, 4'h0);
    check("rst_kidx", kidx1, 2'h0);
    check("rst_last", last1, 1'b0);
    check("rst_err", err1, 1'b0);
    check("rst_busy3", busy3, 1'b0);

    // Encrypt order, ready always high
    push_key(0, 0, 0, 1'b0, 1'b1);
    load_des(KEY_A, 1'b0);
    drain(0, 0, 0, 200);
    check("enc_busy_cycles", busy_cnt1, 17);
    check("enc_keys", hs1, 16);

    // Decrypt order
    push_key(0, 0, 0, 1'b1, 1'b1);
    load_des(KEY_A, 1'b1);
    drain(0, 0, 0, 200);
    check("dec_busy_cycles", busy_cnt1, 17);
    check("dec_keys", hs1, 16);

    // Backpressure with an ignored mid-stream load
    push_key(0, 0, 0, 1'b0, 1'b1);
    load_des(KEY_A, 1'b0);
    drain(1, 1, 0, 400);
    check("bp_keys", hs1, 16);

    // Reset after five handshakes
    push_key(0, 0, 0, 1'b0, 1'b1);
    load_des(KEY_A, 1'b0);
    for (int i = 0; i < 100 && hs1 < 5; i++) @(posedge clk);
    #1 rst_n = 1'b0; ready = 1'b0;
    exp_q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; ready = 1'b1;
    check("mid_rst_busy", busy1, 1'b0);
    check("mid_rst_valid", valid1, 1'b0);
    check("mid_rst_rk", rk1, 48'h0);
    check("mid_rst_round", round1, 4'h0);
    check("mid_rst_kidx", kidx1, 2'h0);
    check("mid_rst_last", last1, 1'b0);
    check("mid_rst_keys", hs1, 5);
    push_key(0, 0, 0, 1'b1, 1'b1);
    load_des(KEY_A, 1'b1);
    drain(0, 0, 0, 200);
    check("post_rst_keys", hs1, 16);

    // 3DES: enc / dec / enc
    push_key(1, 0, 0, 1'b0, 1'b0);
    push_key(1, 1, 1, 1'b1, 1'b0);
    push_key(1, 2, 2, 1'b0, 1'b1);
    load_tdes({KEY_Z, ~KEY_A, KEY_A}, 3'b010);
    drain(0, 0, 0, 300);
    check("tdes_busy_cycles", busy_cnt3, 51);
    check("tdes_keys", hs3, 48);

    // 3DES: different key placement, random ready, ignored load
    push_key(1, 0, 1, 1'b1, 1'b0);
    push_key(1, 1, 2, 1'b0, 1'b0);
    push_key(1, 2, 0, 1'b0, 1'b1);
    load_tdes({KEY_A, KEY_Z, ~KEY_A}, 3'b001);
    drain(1, 0, 1, 800);
    check("tdes_bp_keys", hs3, 48);

`ifdef KEYSCHED_PARITY_CHK_EN
    @(posedge clk); #1;
    key1 = 64'h133457799BBCDFF0; dec1 = 1'b0; load1 = 1'b1; hs1 = 0;
    @(posedge clk); #1;
    load1 = 1'b0;
    check("par_err_pulse", err1, 1'b1);
    check("par_busy", busy1, 1'b0);
    @(posedge clk); #1;
    check("par_err_clear", err1, 1'b0);
    check("par_no_valid", valid1, 1'b0);
    check("par_no_keys", hs1, 0);
    push_key(0, 0, 0, 1'b0, 1'b1);
    load_des(KEY_A, 1'b0);
    drain(0, 0, 0, 200);
    check("par_reload_keys", hs1, 16);
`else
    check("err_tied1", err1, 1'b0);
    check("err_tied3", err3, 1'b0);
`endif

    check("q1_empty", exp_q1.size(), 0);
    check("q3_empty", exp_q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
